// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: PC/instr/sideband with valid/ready,
// 2-entry skid buffer, stall, flush-to-NOP and saturating perf counters.
module pipe_stage_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          SIDE_W    = 8,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [SIDE_W-1:0]  side_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [SIDE_W-1:0]  side_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SIDE_W-1:0]  side;
  } beat_t;

  localparam beat_t RST_BEAT = '{
    pc:    '0,
    instr: NOP_INSTR,
    side:  '0
  };

  beat_t            main_q;
  beat_t            skid_q;
  beat_t            in_beat;
  logic             main_valid;
  logic             skid_valid;
  logic             push;
  logic             pop;
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign in_beat.pc    = pc_i;
  assign in_beat.instr = instr_i;
  assign in_beat.side  = side_i;

  // ready depends only on the skid flop, never on out_ready_i/stall_i
  assign in_ready_o = ~skid_valid;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = main_valid & out_ready_i & ~stall_i;

  assign out_valid_o = main_valid;
  assign pc_o        = main_q.pc;
  assign instr_o     = main_q.instr;
  assign side_o      = main_q.side;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= RST_BEAT;
      skid_q     <= RST_BEAT;
    end else if (flush_i) begin
      main_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      main_q.instr <= NOP_INSTR;
      main_q.side  <= '0;
    end else if (!main_valid || pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (push) begin
        main_q     <= in_beat;
        main_valid <= 1'b1;
      end else begin
        // bubble: pc keeps the last beat's value
        main_valid   <= 1'b0;
        main_q.instr <= NOP_INSTR;
        main_q.side  <= '0;
      end
    end else if (push) begin
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
    end
  end

  assign stall_evt = main_valid & ~pop & ~flush_i;
  assign flush_evt = flush_i & (main_valid | skid_valid);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_evt && !(&flush_q)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  side;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic [7:0]  side_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_ready_i = 1'b0;

  logic        in_ready_o, out_valid_o;
  logic [31:0] pc_o, instr_o;
  logic [7:0]  side_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        in_ready2, out_valid2;
  logic [31:0] pc2, instr2;
  logic [7:0]  side2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int checks = 0;
  int errors = 0;

  beat_t       mq[$];
  logic [31:0] m_pc;
  longint unsigned m_stall;
  longint unsigned m_flush;
  bit          acc;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(
    .NOP_INSTR(NOP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .side_i(side_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .instr_o(instr_o), .side_o(side_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_stage_reg #(
    .NOP_INSTR(NOP),
    .CNT_W(2)
  ) dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready2),
    .pc_i(pc_i), .instr_i(instr_i), .side_i(side_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .out_valid_o(out_valid2), .out_ready_i(out_ready_i),
    .pc_o(pc2), .instr_o(instr2), .side_o(side2),
    .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
  );

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] sat(longint unsigned v, int w);
    longint unsigned lim;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc    = '0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  // one clock edge of the stage, described as a FIFO of held beats
  function automatic void model_step();
    bit    vld, rdy, pop, push;
    beat_t b;
    vld  = mq.size() > 0;
    rdy  = mq.size() < 2;
    pop  = vld && out_ready_i && !stall_i;
    push = in_valid_i && rdy;
    acc  = push;
    if (flush_i) begin
      if (vld) m_flush++;
      mq.delete();
    end else begin
      if (vld && !pop) m_stall++;
      if (pop) void'(mq.pop_front());
      if (push) begin
        b.pc    = pc_i;
        b.instr = instr_i;
        b.side  = side_i;
        mq.push_back(b);
      end
    end
    if (mq.size() > 0) m_pc = mq[0].pc;
  endfunction

  function automatic void check_all();
    bit          v;
    logic [31:0] ei;
    logic [7:0]  es;
    v  = mq.size() > 0;
    ei = v ? mq[0].instr : NOP;
    es = v ? mq[0].side : 8'h00;
    chk("out_valid", 64'(out_valid_o), 64'(v));
    chk("in_ready", 64'(in_ready_o), 64'(mq.size() < 2));
    chk("pc", 64'(pc_o), 64'(m_pc));
    chk("instr", 64'(instr_o), 64'(ei));
    chk("side", 64'(side_o), 64'(es));
    chk("stall_cnt", 64'(stall_cnt_o), sat(m_stall, 16));
    chk("flush_cnt", 64'(flush_cnt_o), sat(m_flush, 16));
    chk("w2_out_valid", 64'(out_valid2), 64'(v));
    chk("w2_in_ready", 64'(in_ready2), 64'(mq.size() < 2));
    chk("w2_pc", 64'(pc2), 64'(m_pc));
    chk("w2_instr", 64'(instr2), 64'(ei));
    chk("w2_side", 64'(side2), 64'(es));
    chk("w2_stall_cnt", 64'(stall_cnt2), sat(m_stall, 2));
    chk("w2_flush_cnt", 64'(flush_cnt2), sat(m_flush, 2));
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic drive(bit v, logic [31:0] pc, logic [31:0] ins,
                       logic [7:0] sd);
    in_valid_i = v;
    pc_i       = pc;
    instr_i    = ins;
    side_i     = sd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    stall_i     = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
  endtask

  // reset asserted between edges and held across one edge
  task automatic do_reset();
    rst_i = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
    rst_i = 1'b1;
    acc   = 1'b1;
  endtask

  initial begin
    idle();
    #2;
    do_reset();
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_instr", 64'(instr_o), 64'(NOP));

    // streaming at full rate
    out_ready_i = 1'b1;
    drive(1'b1, 32'h00, 32'h0000_0111, 8'h01);
    tick();
    chk("t1_pc0", 64'(pc_o), 64'h00);
    chk("t1_v0", 64'(out_valid_o), 64'd1);
    drive(1'b1, 32'h04, 32'h0000_0222, 8'h02);
    tick();
    chk("t1_pc1", 64'(pc_o), 64'h04);
    chk("t1_rdy1", 64'(in_ready_o), 64'd1);
    drive(1'b1, 32'h08, 32'h0000_0333, 8'h03);
    tick();
    chk("t1_pc2", 64'(pc_o), 64'h08);
    chk("t1_instr2", 64'(instr_o), 64'h333);
    idle();
    out_ready_i = 1'b1;
    tick();
    chk("t1_empty", 64'(out_valid_o), 64'd0);
    chk("t1_stall", 64'(stall_cnt_o), 64'd0);

    // backpressure fills the skid
    do_reset();
    out_ready_i = 1'b0;
    drive(1'b1, 32'h10, 32'h0000_0A0A, 8'h0A);
    tick();
    drive(1'b1, 32'h14, 32'h0000_0B0B, 8'h0B);
    tick();
    chk("t2_full_rdy", 64'(in_ready_o), 64'd0);
    chk("t2_pcA", 64'(pc_o), 64'h10);
    idle();
    tick();
    chk("t2_rdy_hold", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    tick();
    chk("t2_pcB", 64'(pc_o), 64'h14);
    chk("t2_rdy_back", 64'(in_ready_o), 64'd1);
    tick();
    chk("t2_drained", 64'(out_valid_o), 64'd0);
    chk("t2_pc_hold", 64'(pc_o), 64'h14);
    chk("t2_stall", 64'(stall_cnt_o), 64'd2);

    // hazard stall with downstream ready
    do_reset();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h20, 32'h00A0_0093, 8'h5A);
    tick();
    idle();
    out_ready_i = 1'b1;
    stall_i     = 1'b1;
    repeat (3) tick();
    chk("t3_pc", 64'(pc_o), 64'h20);
    chk("t3_instr", 64'(instr_o), 64'h00A0_0093);
    chk("t3_stall", 64'(stall_cnt_o), 64'd3);
    stall_i = 1'b0;
    drive(1'b1, 32'h24, 32'h0000_0C0C, 8'h0C);
    tick();
    chk("t3_next", 64'(pc_o), 64'h24);
    idle();
    tick();

    // flush with both entries full and input offered
    do_reset();
    drive(1'b1, 32'h30, 32'h0000_0D0D, 8'h0D);
    tick();
    drive(1'b1, 32'h34, 32'h0000_0E0E, 8'h0E);
    tick();
    flush_i = 1'b1;
    drive(1'b1, 32'h99, 32'h0000_0F0F, 8'h0F);
    tick();
    chk("t4_valid", 64'(out_valid_o), 64'd0);
    chk("t4_instr", 64'(instr_o), 64'(NOP));
    chk("t4_side", 64'(side_o), 64'd0);
    chk("t4_pc", 64'(pc_o), 64'h30);
    chk("t4_rdy", 64'(in_ready_o), 64'd1);
    chk("t4_fcnt", 64'(flush_cnt_o), 64'd1);
    idle();
    out_ready_i = 1'b1;
    tick();
    tick();
    chk("t4_no_ghost", 64'(out_valid_o), 64'd0);

    // flush while empty, then saturation of the narrow counter
    flush_i = 1'b1;
    tick();
    chk("t5_fcnt", 64'(flush_cnt_o), 64'd1);
    flush_i = 1'b0;
    drive(1'b1, 32'h40, 32'h0000_1111, 8'h11);
    tick();
    idle();
    out_ready_i = 1'b1;
    stall_i     = 1'b1;
    repeat (5) tick();
    chk("t5_sat2", 64'(stall_cnt2), 64'd3);
    chk("t5_wide", 64'(stall_cnt_o), 64'd6);
    stall_i = 1'b0;
    tick();

    // asynchronous reset mid-stream
    do_reset();
    out_ready_i = 1'b1;
    drive(1'b1, 32'h50, 32'h0000_2222, 8'h22);
    tick();
    drive(1'b1, 32'h54, 32'h0000_3333, 8'h33);
    tick();
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", 64'(out_valid_o), 64'd0);
    chk("t6_pc", 64'(pc_o), 64'd0);
    chk("t6_instr", 64'(instr_o), 64'(NOP));
    check_all();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("t6_rdy", 64'(in_ready_o), 64'd1);
    drive(1'b1, 32'h60, 32'h0000_4444, 8'h44);
    tick();
    chk("t6_pc_new", 64'(pc_o), 64'h60);
    chk("t6_v_new", 64'(out_valid_o), 64'd1);

    // randomized traffic; upstream holds a beat until it is accepted
    acc = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      if (!in_valid_i || acc) begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom,
              8'($urandom_range(0, 255)));
      end
      out_ready_i = $urandom_range(0, 9) < 7;
      stall_i     = $urandom_range(0, 9) < 2;
      flush_i     = $urandom_range(0, 24) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
